byte_to_word_packer: RTL
========================

Name: byte_to_word_packer

Overview:
- Width adapter that packs the 8-bit packet byte stream (data/valid/ready/last) into WORD_BYTES-wide words with per-byte keep and last flags.
- Sits between processor_controller's ingress output and a wide-datapath processor, such as a 32-bit GAPL-generated stream core.
- Carries packet boundaries intact: a word never spans two packets.

Parameters:
- WORD_BYTES, 4: bytes per output word; legal range 2..8.
- BIG_ENDIAN, 0: 0 places first-arriving byte in bits [7:0]; 1 places it in the most-significant byte.
- PAD_BYTE, 8'h00: value driven in unfilled lanes of a short final word.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  ingress byte.
- in_valid  input  1  ingress byte valid.
- in_ready  output  1  ingress byte accepted when in_valid && in_ready.
- in_last  input  1  ingress byte is final byte of packet.
- out_data  output  8*WORD_BYTES  packed word.
- out_valid  output  1  word valid.
- out_ready  input  1  downstream accepts word when out_valid && out_ready.
- out_keep  output  WORD_BYTES  bit k=1 means arrival-order byte k is real data; always contiguous from bit 0.
- out_last  output  1  word holds final byte of packet.

Behaviour:
- Reset state (asynchronous):
  - out_valid=0, out_data=0, out_keep=0, out_last=0.
  - Accumulator cleared, byte count=0.
  - Any partially packed word is discarded; no partial word is emitted after reset.
- Storage: an accumulator (WORD_BYTES byte lanes plus a count of 0..WORD_BYTES-1) and a registered output stage.
- in_ready = !out_valid || out_ready. Combinational from out_valid and out_ready only, never from in_valid. Reads 1 immediately after reset.
- Accepted byte with count < WORD_BYTES-1 and in_last=0:
  - Byte is written to lane index count (lane mapping per BIG_ENDIAN).
  - count increments.
- Completing byte: accepted byte with count == WORD_BYTES-1, or in_last=1. On that edge:
  - Output register loads the accumulator lanes plus this byte.
  - Unfilled lanes are set to PAD_BYTE.
  - out_keep = (1 << (count+1)) - 1.
  - out_last = in_last.
  - out_valid set to 1.
  - count returns to 0 and accumulator lanes reset to PAD_BYTE.
- Latency: completing byte accepted on edge N gives out_valid=1 after edge N.
- Throughput: 1 byte/cycle sustained with out_ready held high. One word every WORD_BYTES cycles, or sooner on in_last.
- Output hold:
  - While out_valid && !out_ready, out_data, out_keep and out_last are stable and in_ready=0.
  - No byte is accepted, dropped or reordered during the hold.
- Output handoff:
  - When out_valid && out_ready and no completing byte arrives on the same edge, out_valid clears.
  - When out_valid && out_ready and a completing byte arrives on the same edge, the new word loads and out_valid stays 1 (back-to-back, no bubble).
- Lane mapping:
  - BIG_ENDIAN=0: arrival byte k goes to bits [8k+7:8k].
  - BIG_ENDIAN=1: arrival byte k goes to bits [8(WORD_BYTES-1-k)+7 : 8(WORD_BYTES-1-k)].
  - out_keep bit k always refers to arrival byte k, independent of BIG_ENDIAN.
- Packet boundaries:
  - in_last on a full word produces out_keep all-ones and out_last=1.
  - A 1-byte packet produces out_keep=1 and out_last=1.
  - Zero-length packets cannot occur, because last always rides on a byte.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.
- No internal timeout: a partial word waits indefinitely for more bytes or in_last.

Test Plan:
- Full words, WORD_BYTES=4, BIG_ENDIAN=0, out_ready=1: bytes 01..08, in_last on 08 -> 0x04030201 keep 4'b1111 last=0, then 0x08070605 keep 4'b1111 last=1. Each word is valid one cycle after its completing byte; in_ready stays 1 throughout.
- Short final word: 5 bytes 11..15, last on 15 -> 0x14131211 keep 4'b1111 last=0, then 0x00000015 keep 4'b0001 last=1. With PAD_BYTE=8'hAA the second word is 0xAAAAAA15.
- Big-endian: BIG_ENDIAN=1, bytes 01,02,03 with last on 03 -> 0x010203AA when PAD_BYTE=AA, keep 4'b0111, last=1.
- Backpressure: out_ready=0 for 10 cycles after the first word goes valid -> out_data/keep/last stable and in_ready=0 for all 10 cycles; no ingress byte lost. Raising out_ready passes the word, and the next word arrives bubble-free if its completing byte is on the same edge.
- Back-to-back single-byte packets: bytes A0,A1,A2 each with in_last=1, out_ready=1 -> three words 0x000000A0, 0x000000A1, 0x000000A2, each keep 4'b0001 last=1, on consecutive cycles.
- Asynchronous reset mid-packet: assert reset after 2 of 4 bytes accepted -> out_valid=0 immediately, without waiting for a clock edge. Then send bytes 21..24 with last on 24 -> single word 0x24232221 keep 4'b1111 last=1; no stale lanes appear.

Source files
------------

// File: rtl/byte_to_word_packer.sv
// byte_to_word_packer
//
// Packs an 8-bit packet byte stream into WORD_BYTES-wide words. Each output
// word carries a per-byte keep mask and a last flag. A word never spans two
// packets: a byte flagged in_last closes the current word early, and the
// unfilled lanes are driven with PAD_BYTE.
//
// Parameters:
//   WORD_BYTES  bytes per output word (2..8)
//   BIG_ENDIAN  0: first-arriving byte in bits [7:0]; 1: first byte in MS lane
//   PAD_BYTE    value driven in unfilled lanes of a short final word
//
// Ports:
//   clock      system clock, all state on rising edge
//   reset      asynchronous, active-high reset
//   in_data    ingress byte
//   in_valid   ingress byte valid
//   in_ready   ingress byte accepted when in_valid && in_ready
//   in_last    ingress byte is the final byte of its packet
//   out_data   packed word
//   out_valid  word valid
//   out_ready  downstream accepts word when out_valid && out_ready
//   out_keep   bit k set means arrival-order byte k is real data
//   out_last   word holds the final byte of its packet
//
// Handshake: both sides use valid/ready. A transfer happens on a rising edge
// where valid && ready are both 1. A source holds valid and its payload
// stable until that transfer happens. in_ready depends only on the output
// stage (out_valid, out_ready), never on in_valid.

module byte_to_word_packer #(
    parameter int         WORD_BYTES = 4,
    parameter bit         BIG_ENDIAN = 1'b0,
    parameter logic [7:0] PAD_BYTE   = 8'h00
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    output logic [8*WORD_BYTES-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_BYTES-1:0]   out_keep,
    output logic                    out_last
);

    localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    // Accumulator lanes are kept in arrival order. Endian mapping is applied
    // only when a word is handed to the output register.
    logic [7:0]              acc [WORD_BYTES];
    logic [CW-1:0]           count;

    logic                    accept;
    logic                    complete;
    logic [7:0]              lane_byte;
    logic [8*WORD_BYTES-1:0] next_data;
    logic [WORD_BYTES-1:0]   next_keep;

    // The input can advance whenever the output register is empty or is
    // being drained on this edge.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign complete = accept && (in_last || (count == CW'(WORD_BYTES - 1)));

    // Word that the output register loads on a completing byte. Lanes below
    // count come from the accumulator, lane count takes the incoming byte,
    // and higher lanes get padding.
    always_comb begin
        next_data = '0;
        next_keep = '0;
        lane_byte = PAD_BYTE;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (k < int'(count)) begin
                lane_byte = acc[k];
            end else if (k == int'(count)) begin
                lane_byte = in_data;
            end else begin
                lane_byte = PAD_BYTE;
            end
            next_keep[k] = (k <= int'(count));
            if (BIG_ENDIAN) begin
                next_data[8*(WORD_BYTES-1-k) +: 8] = lane_byte;
            end else begin
                next_data[8*k +: 8] = lane_byte;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            for (int k = 0; k < WORD_BYTES; k++) begin
                acc[k] <= 8'h00;
            end
        end else begin
            if (complete) begin
                // A completing byte is only accepted when the output register
                // is free or draining on this edge, so loading here never
                // overwrites an unconsumed word. out_valid stays 1 across a
                // same-edge handoff.
                out_data  <= next_data;
                out_keep  <= next_keep;
                out_last  <= in_last;
                out_valid <= 1'b1;
                count     <= '0;
                for (int k = 0; k < WORD_BYTES; k++) begin
                    acc[k] <= PAD_BYTE;
                end
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (accept) begin
                    acc[count] <= in_data;
                    count      <= count + CW'(1);
                end
            end
        end
    end

endmodule
